mem_req_queue: RTL
==================

# mem_req_queue

- Request front end directly upstream of the SDRAM memory controller.
- Accepts read/write requests from a client via a valid/ready handshake and buffers them in a small FIFO.
- Issues the requests one at a time on the controller's `ready`/`we`/`re`/`addr`/`data_in` interface.
- Returns read data to the client in request order through a held response register.
- Holds off all issue until SDRAM initialization has completed.

## Interface
Parameters:
- `DEPTH`, 4: request FIFO entries; power of two, ≥2.
- `TIMEOUT`, 64: read-data watchdog limit in cycles; used only with the configuration macro.

Ports:
- `clock` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-high reset.
- `req_valid` in 1: client request present.
- `req_ready` out 1: FIFO can accept; equals !full.
- `req_we` in 1: 1 = write, 0 = read.
- `req_addr` in 22: word address.
- `req_wdata` in 16: write data; ignored for reads.
- `resp_valid` out 1: read data available.
- `resp_ready` in 1: client consumes response.
- `resp_rdata` out 16: read data.
- `mc_init_done` in 1: controller initialization complete (level).
- `mc_ready` in 1: controller idle.
- `mc_we`, `mc_re` out 1: single-cycle command strobes.
- `mc_addr` out 22: command address.
- `mc_data_in` out 16: write data.
- `mc_data_out` in 16: read data from the controller.
- `mc_data_out_valid` in 1: read data strobe.
- `busy` out 1: FSM not in IDLE, or FIFO non-empty.
- `timeout_err` out 1: sticky watchdog flag (see Configuration).

## Operation
FIFO:
- Push when `req_valid && req_ready`. Entry is {we, addr, wdata} (39 bits).
- Pop happens when the FSM leaves IDLE.
- Pointers are log2(DEPTH) bits and wrap naturally.
- Count is $clog2(DEPTH+1) bits.
- When full, `req_ready`=0 even if a pop occurs in the same cycle. No bypass.
- Push and pop in the same cycle when not full: count is unchanged.

FSM states: IDLE, ISSUE, GUARD, WAIT_DATA, RESP, WAIT_RDY.
- IDLE: if FIFO non-empty && `mc_init_done` && `mc_ready`, pop the head into the command register and go to ISSUE.
- ISSUE: drive `mc_we`=cmd.we or `mc_re`=!cmd.we for exactly this cycle, then go to GUARD.
- GUARD: one cycle in which `mc_ready` is ignored. Next state is WAIT_DATA for a read, WAIT_RDY for a write.
- WAIT_DATA: on `mc_data_out_valid`, capture `mc_data_out` into `resp_rdata` and go to RESP.
- RESP: hold `resp_valid`=1. On `resp_ready`, go to WAIT_RDY.
- WAIT_RDY: when `mc_ready`=1, go to IDLE.

Data capture:
- `mc_data_out_valid` is also sampled in GUARD. If asserted there, data is captured and the next state is RESP.
- `mc_data_out_valid` is ignored in all other states.

Command outputs:
- `mc_addr`/`mc_data_in` are driven from the command register.
- They are stable from ISSUE until the next ISSUE.

Other rules:
- `mc_init_done` falling mid-operation does not abort the current command. It only blocks the next issue from IDLE.
- Reset mid-operation: FIFO is emptied, FSM returns to IDLE, and any in-flight response is discarded.

## Timing
- Reset values: `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `mc_we`=0, `mc_re`=0, `mc_addr`=0, `mc_data_in`=0, `busy`=0, `timeout_err`=0.
- All outputs are registered or decoded from registered state. There is no combinational path from any input to `mc_*`.
- `req_ready` depends only on count.
- Minimum latency, push to strobe: 2 cycles. Push at edge N; IDLE sees non-empty at N+1; strobe at N+2.
- Back-to-back writes: ≥4 cycles per command (IDLE, ISSUE, GUARD, WAIT_RDY), plus any `mc_ready`-low time.
- `resp_valid` rises the cycle after the `mc_data_out_valid` sample.

## Configuration
Macro `MEM_REQ_TIMEOUT_EN`.
- Defined:
  - A cycle counter clears on entry to GUARD for reads and increments in GUARD/WAIT_DATA.
  - When it reaches TIMEOUT, `timeout_err` sets (sticky until reset).
  - `resp_rdata` is loaded with 16'hDEAD and the FSM goes to RESP.
- Not defined:
  - No counter exists.
  - `timeout_err` is tied to 0.
  - WAIT_DATA waits indefinitely.

## Structure
- Package `mem_req_pkg` holds:
  - the FSM state enum `mq_state_t`;
  - the packed struct `mem_req_t` {we, addr[21:0], wdata[15:0]};
  - constants ADDR_W=22, DATA_W=16, TIMEOUT_FILL=16'hDEAD.
- One sub-module, `mem_req_fifo`, parameterized on DEPTH and element type width. It provides push/pop/full/empty/count.
- The FSM, command register and response register live in the top module.

## Test plan
- Reset behaviour: reset asserted for 2 cycles mid-read with 3 entries queued -> all reset values listed under Timing, FIFO empty, no further `mc_re` strobes.
- Init hold-off: `mc_init_done`=0, push write (addr 22'h00123, data 16'hBEEF) -> no strobe. Raise `mc_init_done` -> one `mc_we` pulse with `mc_addr`=22'h00123 and `mc_data_in`=16'hBEEF.
- Fill, then order:
  - push 4 requests W(1,16'h1111), R(1), W(2,16'h2222), R(2) with `mc_ready` held 0 -> `req_ready`=0 after the 4th push and a 5th push is rejected;
  - release `mc_ready` -> strobes appear in push order;
  - reads return 16'h1111 then 16'h2222.
- Response backpressure: read completes with `mc_data_out`=16'hA5A5 while `resp_ready`=0 for 5 cycles -> `resp_valid` held and `resp_rdata` stable at 16'hA5A5 throughout. The next command is not issued until after `resp_ready`.
- Early data: `mc_data_out_valid` pulsed during GUARD -> data is captured, `resp_valid` asserts on the next cycle, and no hang occurs in WAIT_DATA.
- Watchdog (`MEM_REQ_TIMEOUT_EN` defined, TIMEOUT=8): read with no `mc_data_out_valid` -> `timeout_err`=1 and `resp_rdata`=16'hDEAD. `timeout_err` remains set across later successful reads until reset.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared types and constants for the SDRAM request front end.
package mem_req_pkg;

  localparam int unsigned ADDR_W = 22;
  localparam int unsigned DATA_W = 16;
  localparam logic [DATA_W-1:0] TIMEOUT_FILL = 16'hDEAD;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    GUARD     = 3'd2,
    WAIT_DATA = 3'd3,
    RESP      = 3'd4,
    WAIT_RDY  = 3'd5
  } mq_state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

  localparam int unsigned REQ_W = $bits(mem_req_t);

endpackage

// File: rtl/mem_req_fifo.sv
// Request buffer: power-of-two ring with naturally wrapping pointers, no bypass.
module mem_req_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 39
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full blocks a push even when a pop happens in the same cycle.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = store[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mem_req_queue.sv
// Request front end for the SDRAM controller: buffers client requests, issues them one at a time,
// returns read data in order. Optional read-data watchdog enabled by MEM_REQ_TIMEOUT_EN.
module mem_req_queue
  import mem_req_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  input  logic              mc_init_done,
  input  logic              mc_ready,
  output logic              mc_we,
  output logic              mc_re,
  output logic [ADDR_W-1:0] mc_addr,
  output logic [DATA_W-1:0] mc_data_in,
  input  logic [DATA_W-1:0] mc_data_out,
  input  logic              mc_data_out_valid,
  output logic              busy,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_cfg
    $error("mem_req_queue: DEPTH must be a power of two >= 2 and TIMEOUT >= 2");
  end

  mq_state_t         state;
  mem_req_t          cmd;
  mem_req_t          req_in;
  logic [REQ_W-1:0]  fifo_head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              pop;

  assign req_in = '{we: req_we, addr: req_addr, wdata: req_wdata};

  mem_req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (req_valid),
    .push_data (req_in),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Issue leaves IDLE only when init is done and the controller is idle.
  assign pop = (state == IDLE) && !fifo_empty && mc_init_done && mc_ready;

  assign req_ready  = !fifo_full;
  assign busy       = (state != IDLE) || (fifo_count != '0);
  assign resp_valid = (state == RESP);
  assign mc_we      = (state == ISSUE) && cmd.we;
  assign mc_re      = (state == ISSUE) && !cmd.we;
  assign mc_addr    = cmd.addr;
  assign mc_data_in = cmd.wdata;

`ifdef MEM_REQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;
  logic             tmo_err;
  assign timeout_err = tmo_err;
`else
  assign timeout_err = 1'b0;
`endif

  // Command sequencer; command and response registers hold between transactions.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      cmd        <= '0;
      resp_rdata <= '0;
`ifdef MEM_REQ_TIMEOUT_EN
      tmo_cnt    <= '0;
      tmo_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            cmd   <= mem_req_t'(fifo_head);
            state <= ISSUE;
          end
        end
        ISSUE: begin
          state <= GUARD;
`ifdef MEM_REQ_TIMEOUT_EN
          if (!cmd.we) tmo_cnt <= '0;
`endif
        end
        GUARD: begin
          // Controller may still show ready here; data can already arrive.
          if (cmd.we) begin
            state <= WAIT_RDY;
          end else if (mc_data_out_valid) begin
            resp_rdata <= mc_data_out;
            state      <= RESP;
          end else begin
            state <= WAIT_DATA;
`ifdef MEM_REQ_TIMEOUT_EN
            tmo_cnt <= tmo_cnt + TMO_W'(1);
`endif
          end
        end
        WAIT_DATA: begin
          if (mc_data_out_valid) begin
            resp_rdata <= mc_data_out;
            state      <= RESP;
          end
`ifdef MEM_REQ_TIMEOUT_EN
          else if (tmo_cnt >= TMO_W'(TIMEOUT - 1)) begin
            tmo_err    <= 1'b1;
            resp_rdata <= TIMEOUT_FILL;
            state      <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
`endif
        end
        RESP: begin
          if (resp_ready) state <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (mc_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
